// File: rtl/delay_pulse_gen_if.sv
// rtl/delay_pulse_gen_if.sv - control/status bundle for the trigger-delayed pulse generator
//
// Purpose: groups the enable, time-base, trigger, programming and status
// signals of delay_pulse_gen so that they travel as one port.
//
// Signals:
//   i_en       block enable; low forces the generator idle
//   i_tick     one-clk-wide time-base strobe from the prescaler
//   i_trig     asynchronous external trigger; rising edge starts a sequence
//   i_delay    delay in ticks, sampled at trigger acceptance
//   i_width    pulse width in ticks, sampled at trigger acceptance
//   i_clr_ovr  clears the sticky overrun flag
//   o_out      delayed output pulse, registered
//   o_busy     high while a sequence is in progress
//   o_done     one-clk strobe at end of sequence
//   o_ovr      sticky flag: trigger edge arrived while busy
//
// Modports: master drives the inputs and observes status, slave is the generator.

interface delay_pulse_gen_if #(
    parameter int DELAY_W = 18,
    parameter int WIDTH_W = 18
);
    logic               i_en;
    logic               i_tick;
    logic               i_trig;
    logic [DELAY_W-1:0] i_delay;
    logic [WIDTH_W-1:0] i_width;
    logic               i_clr_ovr;
    logic               o_out;
    logic               o_busy;
    logic               o_done;
    logic               o_ovr;

    modport master (
        output i_en, i_tick, i_trig, i_delay, i_width, i_clr_ovr,
        input  o_out, o_busy, o_done, o_ovr
    );

    modport slave (
        input  i_en, i_tick, i_trig, i_delay, i_width, i_clr_ovr,
        output o_out, o_busy, o_done, o_ovr
    );
endinterface

// File: rtl/delay_pulse_gen.sv
// rtl/delay_pulse_gen.sv - trigger-delayed pulse generator clocked by a prescaled tick
//
// Purpose: on a rising edge of the external trigger, waits i_delay ticks and
// then drives o_out high for i_width ticks, reporting busy/done/overrun.
//
// Ports:
//   clk   system clock, all state updates on the rising edge
//   rst   asynchronous active-high reset
//   bus   delay_pulse_gen_if.slave (enable, tick, trigger, programming, status)

module delay_pulse_gen #(
    parameter int DELAY_W = 18,
    parameter int WIDTH_W = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    delay_pulse_gen_if.slave      bus
);
    localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH_W-1:0] r_width_lat;
    logic               r_out;
    logic               r_busy;
    logic               r_done;
    logic               r_ovr;
    logic               r_s0;
    logic               r_s1;
    logic               r_s2;

    logic               w_edge;
    logic               w_ovr_set;
    logic               w_cnt_last;

    // s0 is the metastability catcher; the edge is taken between s1 and s2.
    assign w_edge     = r_s1 & ~r_s2;
    assign w_ovr_set  = bus.i_en && w_edge && (r_state != S_IDLE);
    assign w_cnt_last = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s0 <= bus.i_trig;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    // Set has priority so an overrun landing on the clear edge is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr <= 1'b0;
        end else if (w_ovr_set) begin
            r_ovr <= 1'b1;
        end else if (bus.i_clr_ovr) begin
            r_ovr <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_width_lat <= '0;
            r_out       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!bus.i_en) begin
                r_state     <= S_IDLE;
                r_cnt       <= '0;
                r_width_lat <= '0;
                r_out       <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_edge) begin
                            r_width_lat <= bus.i_width;
                            if (bus.i_delay != '0) begin
                                r_cnt   <= CNT_W'(bus.i_delay);
                                r_busy  <= 1'b1;
                                r_state <= S_DELAY;
                            end else if (bus.i_width != '0) begin
                                r_cnt   <= CNT_W'(bus.i_width);
                                r_out   <= 1'b1;
                                r_busy  <= 1'b1;
                                r_state <= S_PULSE;
                            end else begin
                                // Empty sequence: report completion without ever going busy.
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_DELAY: begin
                        if (bus.i_tick) begin
                            if (w_cnt_last) begin
                                if (r_width_lat != '0) begin
                                    r_cnt   <= CNT_W'(r_width_lat);
                                    r_out   <= 1'b1;
                                    r_state <= S_PULSE;
                                end else begin
                                    r_cnt   <= '0;
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end
                        end
                    end
                    S_PULSE: begin
                        if (bus.i_tick) begin
                            if (w_cnt_last) begin
                                r_cnt   <= '0;
                                r_out   <= 1'b0;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_out   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_out  = r_out;
    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_ovr  = r_ovr;

endmodule

// File: tb/tb_delay_pulse_gen.sv
// tb/tb_delay_pulse_gen.sv - directed self-checking bench for delay_pulse_gen

module tb_delay_pulse_gen;
    logic clk;
    logic rst;

    delay_pulse_gen_if #(.DELAY_W(4), .WIDTH_W(4)) bus ();

    delay_pulse_gen #(.DELAY_W(4), .WIDTH_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    logic s_out  [64];
    logic s_busy [64];
    logic s_done [64];
    logic s_ovr  [64];

    int rise_at, fall_at, out_cnt, busy_first, busy_cnt, done_at, done_cnt, done_pairs;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // j indexes clock edges relative to E0, the first edge that samples trig high.
    // Samples are taken 1 time unit after edge j; -1 disables an optional hook.
    task automatic run_seq(input int dly, input int wid, input int tper, input int n,
                           input int trig2_j, input int clr_j, input int en_lo_j,
                           input int en_hi_j, input int rst_j, input int chg_j);
        bus.i_delay = 4'(dly);
        bus.i_width = 4'(wid);
        for (int j = 0; j < n; j++) begin
            bus.i_trig    = (j <= 1) || (trig2_j >= 0 && (j == trig2_j || j == trig2_j + 1));
            bus.i_tick    = (tper > 0) && (j > 0) && (j % tper == 0);
            bus.i_clr_ovr = (j == clr_j);
            bus.i_en      = !(en_lo_j >= 0 && j >= en_lo_j && j < en_hi_j);
            if (j == chg_j) begin
                bus.i_delay = 4'd1;
                bus.i_width = 4'd1;
            end
            @(posedge clk);
            #1;
            s_out[j]  = bus.o_out;
            s_busy[j] = bus.o_busy;
            s_done[j] = bus.o_done;
            s_ovr[j]  = bus.o_ovr;
            if (j == rst_j) begin
                #2;
                rst = 1'b1;
                #1;
                check("async_rst_busy", int'(bus.o_busy), 0);
                check("async_rst_out",  int'(bus.o_out),  0);
                check("async_rst_done", int'(bus.o_done), 0);
            end
        end
        bus.i_trig    = 1'b0;
        bus.i_tick    = 1'b0;
        bus.i_clr_ovr = 1'b0;
        bus.i_en      = 1'b1;
        rise_at = -1; fall_at = -1; out_cnt = 0;
        busy_first = -1; busy_cnt = 0;
        done_at = -1; done_cnt = 0; done_pairs = 0;
        for (int j = 0; j < n; j++) begin
            if (s_out[j] && rise_at < 0) rise_at = j;
            if (rise_at >= 0 && !s_out[j] && fall_at < 0) fall_at = j;
            if (s_out[j]) out_cnt++;
            if (s_busy[j] && busy_first < 0) busy_first = j;
            if (s_busy[j]) busy_cnt++;
            if (s_done[j] && done_at < 0) done_at = j;
            if (s_done[j]) done_cnt++;
            if (j > 0 && s_done[j] && s_done[j-1]) done_pairs++;
        end
        idle_cycles(4);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.i_en      = 1'b1;
        bus.i_tick    = 1'b0;
        bus.i_trig    = 1'b0;
        bus.i_delay   = '0;
        bus.i_width   = '0;
        bus.i_clr_ovr = 1'b0;
        idle_cycles(3);
        check("rst_out",  int'(bus.o_out),  0);
        check("rst_busy", int'(bus.o_busy), 0);
        check("rst_done", int'(bus.o_done), 0);
        check("rst_ovr",  int'(bus.o_ovr),  0);
        rst = 1'b0;

        // Ticks while idle do nothing.
        for (int k = 0; k < 6; k++) begin
            bus.i_tick = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.i_tick = 1'b0;
        check("idle_tick_out",  int'(bus.o_out),  0);
        check("idle_tick_busy", int'(bus.o_busy), 0);
        idle_cycles(3);

        // Basic: acceptance at 2, ticks at 4,8,12 -> rise 12; ticks 16,20 -> fall 20.
        run_seq(3, 2, 4, 28, -1, -1, -1, -1, -1, -1);
        check("basic_rise",      rise_at,    12);
        check("basic_fall",      fall_at,    20);
        check("basic_out_cnt",   out_cnt,    8);
        check("basic_done_at",   done_at,    20);
        check("basic_done_cnt",  done_cnt,   1);
        check("basic_done_pair", done_pairs, 0);
        check("basic_busy_at",   busy_first, 2);
        check("basic_busy_cnt",  busy_cnt,   18);

        // delay=0: out rises at acceptance, falls on the 5th tick (edge 20).
        run_seq(0, 5, 4, 26, -1, -1, -1, -1, -1, -1);
        check("d0_rise",     rise_at,  2);
        check("d0_fall",     fall_at,  20);
        check("d0_done_at",  done_at,  20);
        check("d0_busy_cnt", busy_cnt, 18);

        // delay=0,width=0: done strobe right after acceptance, never busy.
        run_seq(0, 0, 4, 10, -1, -1, -1, -1, -1, -1);
        check("zz_rise",     rise_at,  -1);
        check("zz_done_at",  done_at,  2);
        check("zz_done_cnt", done_cnt, 1);
        check("zz_busy_cnt", busy_cnt, 0);

        // Overrun: second trig sampled at 5, its edge hits DELAY at edge 7.
        run_seq(10, 10, 1, 30, 5, -1, -1, -1, -1, -1);
        check("ovr_rise",     rise_at,  12);
        check("ovr_fall",     fall_at,  22);
        check("ovr_done_at",  done_at,  22);
        check("ovr_pre",      int'(s_ovr[6]), 0);
        check("ovr_set",      int'(s_ovr[7]), 1);
        check("ovr_sticky",   int'(bus.o_ovr), 1);
        bus.i_clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        bus.i_clr_ovr = 1'b0;
        check("ovr_clear", int'(bus.o_ovr), 0);
        idle_cycles(2);
        run_seq(10, 10, 1, 30, 5, 7, -1, -1, -1, -1);
        check("ovr_setwin_pre", int'(s_ovr[6]), 0);
        check("ovr_setwin",     int'(s_ovr[7]), 1);
        check("ovr_setwin_end", int'(bus.o_ovr), 1);
        bus.i_clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        bus.i_clr_ovr = 1'b0;
        check("ovr_clear2", int'(bus.o_ovr), 0);

        // Abort: en low from edge 8 (mid-pulse); a trig while disabled leaves ovr clear.
        run_seq(2, 10, 1, 25, 10, -1, 8, 15, -1, -1);
        check("abort_rise",     rise_at,  4);
        check("abort_out_cnt",  out_cnt,  4);
        check("abort_busy_cnt", busy_cnt, 6);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_ovr",      int'(bus.o_ovr), 0);
        run_seq(1, 1, 1, 10, -1, -1, -1, -1, -1, -1);
        check("fresh_rise",    rise_at, 3);
        check("fresh_fall",    fall_at, 4);
        check("fresh_done_at", done_at, 4);

        // Async reset mid-DELAY, then a clean sequence after release.
        run_seq(10, 3, 1, 12, -1, -1, -1, -1, 6, -1);
        check("rst_mid_busy_before", int'(s_busy[6]), 1);
        check("rst_mid_done_cnt",    done_cnt, 0);
        rst = 1'b0;
        idle_cycles(3);
        run_seq(2, 3, 2, 18, -1, -1, -1, -1, -1, -1);
        check("post_rst_rise",    rise_at, 6);
        check("post_rst_fall",    fall_at, 12);
        check("post_rst_done_at", done_at, 12);

        // Max count with input changes mid-run ignored.
        run_seq(15, 15, 1, 40, -1, -1, -1, -1, -1, 5);
        check("max_rise",     rise_at,  17);
        check("max_fall",     fall_at,  32);
        check("max_out_cnt",  out_cnt,  15);
        check("max_done_at",  done_at,  32);
        check("max_busy_cnt", busy_cnt, 30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
